// File: rtl/barrel_arith_pkg.sv
// Shared types and helpers for the sequential barrel divider.
package barrel_arith_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned CNT_W     = $clog2(DEF_WIDTH);
  localparam int unsigned MAG_W     = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Magnitude of a width-bit operand held in the low bits of value; the
  // most negative value maps to 2^(width-1), which still fits unsigned.
  function automatic logic [MAG_W-1:0] abs_mag(input logic [MAG_W-1:0] value,
                                               input int unsigned       width,
                                               input logic              signed_mode);
    logic is_neg;
    is_neg = signed_mode && (((value >> (width - 1)) & MAG_W'(1)) != '0);
    return is_neg ? (~value + MAG_W'(1)) : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dmag_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Shift in the next dividend bit, trial-subtract, restore on borrow.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, dmag_i};
    rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], ~diff[WIDTH]};
  end

endmodule

// File: rtl/barrel_divider.sv
// Sequential restoring divider with signed/unsigned operands and
// truncate-toward-zero results; fixed WIDTH+1 cycle latency.
module barrel_divider
  import barrel_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned      CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dmag_q;
  logic [WIDTH-1:0] rem_d, quo_d;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             neg_dvd_q, neg_dvs_q;
  logic             dz_q, ovf_q;
  logic             in_ready_q, out_valid_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             div_by_zero_q, overflow_q;

  assign dvd_mag = WIDTH'(abs_mag(MAG_W'(dividend), WIDTH, signed_mode));
  assign dvs_mag = WIDTH'(abs_mag(MAG_W'(divisor), WIDTH, signed_mode));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dmag_i (dmag_q),
    .rem_o  (rem_d),
    .quo_o  (quo_d)
  );

  // Control FSM plus operand/result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dmag_q        <= '0;
      neg_dvd_q     <= 1'b0;
      neg_dvs_q     <= 1'b0;
      dz_q          <= 1'b0;
      ovf_q         <= 1'b0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            neg_dvd_q  <= signed_mode & dividend[WIDTH-1];
            neg_dvs_q  <= signed_mode & divisor[WIDTH-1];
            quo_q      <= dvd_mag;
            dmag_q     <= dvs_mag;
            rem_q      <= '0;
            cnt_q      <= '0;
            dz_q       <= (divisor == '0);
            ovf_q      <= signed_mode && (dividend == MIN_NEG) && (divisor == '1);
            in_ready_q <= 1'b0;
            state_q    <= ITER;
          end
        end
        ITER: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          // With a zero divisor the remainder magnitude is the dividend
          // magnitude, so the sign fix restores the original dividend bits.
          if (dz_q) begin
            quotient_q <= '1;
          end else if (neg_dvd_q ^ neg_dvs_q) begin
            quotient_q <= -quo_q;
          end else begin
            quotient_q <= quo_q;
          end
          remainder_q   <= neg_dvd_q ? -rem_q : rem_q;
          div_by_zero_q <= dz_q;
          overflow_q    <= ovf_q;
          out_valid_q   <= 1'b1;
          state_q       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_barrel_divider.sv
// Scoreboard bench for barrel_divider (WIDTH=8).
module tb_barrel_divider;

  localparam int unsigned W = 8;
  localparam int          LATENCY = 9;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         signed_mode = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  barrel_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  // Reference result from integer / and % plus the two special cases.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    int   sa, sb;
    e = '0;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else if (s && a == 8'h80 && b == 8'hFF) begin
      e.q  = 8'h80;
      e.r  = '0;
      e.ov = 1'b1;
    end else if (s) begin
      sa  = int'($signed(a));
      sb  = int'($signed(b));
      e.q = W'(sa / sb);
      e.r = W'(sa % sb);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r,
                              input logic dz, input logic ov);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.ov = ov;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input exp_t e);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    else n_pass++;
    dividend    = a;
    divisor     = b;
    signed_mode = s;
    in_valid    = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid    = 1'b0;
    dividend    = W'($urandom);
    divisor     = W'($urandom);
    signed_mode = ~s;
  endtask

  // Waits for the result (start = cycles already elapsed since accept),
  // checks latency and value, holds backpressure, then releases.
  task automatic recv(input string tag, input int start, input int hold);
    int   n;
    exp_t e, obs;
    n = start;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (n !== LATENCY || out_valid !== 1'b1)
      $display("FAIL %s_latency: got %0d cycles (out_valid=%b) required %0d", tag, n, out_valid, LATENCY);
    else n_pass++;
    if (out_valid !== 1'b1) return;
    obs.q = quotient; obs.r = remainder; obs.dz = div_by_zero; obs.ov = overflow;
    n_total++;
    if (sb_q.size() == 0) begin
      $display("FAIL %s_result: unexpected result q=%h r=%h", tag, obs.q, obs.r);
      e = obs;
    end else begin
      e = sb_q.pop_front();
      if (obs !== e)
        $display("FAIL %s_result: got q=%h r=%h dz=%b ov=%b required q=%h r=%h dz=%b ov=%b",
                 tag, obs.q, obs.r, obs.dz, obs.ov, e.q, e.r, e.dz, e.ov);
      else n_pass++;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== e.q || remainder !== e.r ||
          div_by_zero !== e.dz || overflow !== e.ov)
        $display("FAIL %s_hold%0d: got v=%b rdy=%b q=%h r=%h required v=1 rdy=0 q=%h r=%h",
                 tag, i, out_valid, in_ready, quotient, remainder, e.q, e.r);
      else n_pass++;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s_release: got out_valid=%b in_ready=%b required 0/1", tag, out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== '0 || remainder !== '0 ||
        div_by_zero !== 1'b0 || overflow !== 1'b0)
      $display("FAIL reset: got rdy=%b v=%b q=%h r=%h dz=%b ov=%b required 1 0 00 00 0 0",
               in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
    else n_pass++;
  endtask

  task automatic test_unsigned();
    send(8'd100, 8'd7, 1'b0, mk(8'h0E, 8'h02, 1'b0, 1'b0));
    recv("u100_7", 0, 0);
    send(8'd255, 8'd16, 1'b0, mk(8'h0F, 8'h0F, 1'b0, 1'b0));
    recv("u255_16", 0, 0);
  endtask

  task automatic test_signed();
    send(8'hF9, 8'h02, 1'b1, mk(8'hFD, 8'hFF, 1'b0, 1'b0));
    recv("s_m7_2", 0, 0);
    send(8'h07, 8'hFE, 1'b1, mk(8'hFD, 8'h01, 1'b0, 1'b0));
    recv("s_7_m2", 0, 0);
    send(8'hF9, 8'hFE, 1'b1, mk(8'h03, 8'hFF, 1'b0, 1'b0));
    recv("s_m7_m2", 0, 0);
  endtask

  task automatic test_special();
    send(8'h80, 8'hFF, 1'b1, mk(8'h80, 8'h00, 1'b0, 1'b1));
    recv("ovf", 0, 0);
    send(8'h05, 8'h00, 1'b0, mk(8'hFF, 8'h05, 1'b1, 1'b0));
    recv("dz_u", 0, 0);
    send(8'hF9, 8'h00, 1'b1, mk(8'hFF, 8'hF9, 1'b1, 1'b0));
    recv("dz_s", 0, 0);
    send(8'h80, 8'h00, 1'b1, mk(8'hFF, 8'h80, 1'b1, 1'b0));
    recv("dz_min", 0, 0);
    send(8'h80, 8'hFF, 1'b0, mk(8'h00, 8'h80, 1'b0, 1'b0));
    recv("u80_ff", 0, 0);
  endtask

  task automatic test_backpressure();
    send(8'd77, 8'd5, 1'b0, mk(8'd15, 8'd2, 1'b0, 1'b0));
    repeat (3) @(negedge clk);
    in_valid = 1'b1;
    dividend = 8'd9;
    divisor  = 8'd3;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL busy_ready: got in_ready=%b required 0", in_ready);
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    recv("bp", 4, 5);
    repeat (12) @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0 || sb_q.size() != 0)
      $display("FAIL bp_no_extra: got out_valid=%b queue=%0d required 0/0", out_valid, sb_q.size());
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    exp_t dropped;
    send(8'd50, 8'd5, 1'b0, mk(8'd10, 8'd0, 1'b0, 1'b0));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dropped = sb_q.pop_back();
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== '0 || remainder !== '0 ||
        div_by_zero !== 1'b0 || overflow !== 1'b0)
      $display("FAIL mid_reset: got rdy=%b v=%b q=%h r=%h dz=%b ov=%b required 1 0 00 00 0 0 (dropped q=%h)",
               in_ready, out_valid, quotient, remainder, div_by_zero, overflow, dropped.q);
    else n_pass++;
    send(8'd200, 8'd3, 1'b0, mk(8'd66, 8'd2, 1'b0, 1'b0));
    recv("after_rst", 0, 0);
  endtask

  task automatic test_sweep();
    logic [W-1:0] corners [9];
    logic [W-1:0] a, b;
    corners = '{8'h00, 8'h01, 8'h02, 8'h07, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 9; i++) begin
        for (int j = 0; j < 9; j++) begin
          send(corners[i], corners[j], 1'(m), model(corners[i], corners[j], 1'(m)));
          recv("corner", 0, 0);
        end
      end
      for (int k = 0; k < 500; k++) begin
        a = W'($urandom);
        b = W'($urandom_range(0, 15) == 0 ? 0 : $urandom);
        send(a, b, 1'(m), model(a, b, 1'(m)));
        recv("rand", 0, 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_backpressure();
    test_mid_reset();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
